// File: rtl/otter_mem_stage.sv
// OTTER MEM-stage load/store unit: single-outstanding req/ack data bus,
// store lane formatting, load extraction/extension, misalign + timeout flags.
//
// Ports:
//   CLK, RST                  clock, sync active-high reset
//   req_valid/req_ready       EX/MEM handshake
//   ALU_RESULT, store_data    effective address, rs2 value
//   mem_we, size, unsigned_ld access type
//   rd_in                     load destination register
//   bus_req/we/addr/wdata/be  registered bus request, held during BUS
//   bus_ack, bus_rdata        bus completion and read word
//   wb_valid, wb_data, wb_rd  one-cycle load writeback
//   misalign, bus_err         one-cycle error pulses
module otter_mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] store_data,
  input  logic        mem_we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [4:0]  rd_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_nx;
  logic        hs;
  logic        mis;
  logic        tmo;
  logic [7:0]  cnt;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [1:0]  ld_off;
  logic [4:0]  ld_rd;
  logic [31:0] sh;
  logic [31:0] ld_data;
  logic [3:0]  be_st;
  logic [31:0] wd_st;

  assign req_ready = (state == IDLE) && !RST;
  assign hs        = req_valid && req_ready;

  always_comb begin
    mis = 1'b0;
    unique case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = ALU_RESULT[0];
      2'b10:   mis = |ALU_RESULT[1:0];
      default: mis = 1'b1;
    endcase
  end

  // cnt holds completed BUS cycles; the current one is cnt+1.
  assign tmo = (state == BUS) && !bus_ack &&
               ((cnt + 8'd1) == 8'(MAX_WAIT));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs && !mis) state_nx = BUS;
      BUS:  if (bus_ack || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    be_st = 4'hF;
    wd_st = store_data;
    unique case (size)
      2'b00: begin
        be_st = 4'b0001 << ALU_RESULT[1:0];
        wd_st = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_st = 4'b0011 << ALU_RESULT[1:0];
        wd_st = {2{store_data[15:0]}};
      end
      default: begin
        be_st = 4'hF;
        wd_st = store_data;
      end
    endcase
  end

  // Word loads are aligned, so ld_off is 0 and sh is the raw word.
  assign sh = bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = sh;
    unique case (ld_size)
      2'b00:
        ld_data = ld_uns ? {24'b0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
      2'b01:
        ld_data = ld_uns ? {16'b0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      ld_size   <= '0;
      ld_uns    <= 1'b0;
      ld_off    <= '0;
      ld_rd     <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      if (hs) begin
        if (mis) begin
          misalign <= 1'b1;
        end else begin
          bus_req   <= 1'b1;
          bus_we    <= mem_we;
          bus_addr  <= {ALU_RESULT[31:2], 2'b00};
          bus_be    <= mem_we ? be_st : 4'hF;
          bus_wdata <= wd_st;
          ld_size   <= size;
          ld_uns    <= unsigned_ld;
          ld_off    <= ALU_RESULT[1:0];
          ld_rd     <= rd_in;
          cnt       <= '0;
        end
      end
      if (state == BUS) begin
        if (bus_ack) begin
          bus_req <= 1'b0;
          if (!bus_we) begin
            wb_valid <= 1'b1;
            wb_data  <= ld_data;
            wb_rd    <= ld_rd;
          end
        end else if (tmo) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_otter_mem_stage.sv
// Directed bench for otter_mem_stage (MAX_WAIT=4).
// One task per scenario, inline comparisons, one summary line.
module tb_otter_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] ALU_RESULT = '0;
  logic [31:0] store_data = '0;
  logic        mem_we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  otter_mem_stage #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .ALU_RESULT(ALU_RESULT), .store_data(store_data),
    .mem_we(mem_we), .size(size), .unsigned_ld(unsigned_ld),
    .rd_in(rd_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge; returns in cycle N+1.
  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] sd, input logic [1:0] sz,
                       input logic uns, input logic [4:0] rd);
    mem_we = we; ALU_RESULT = a; store_data = sd;
    size = sz; unsigned_ld = uns; rd_in = rd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", bus_req); end
    n_cmp++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin n_bad++; $display("FAIL rst_bus got=%b%h%h%h exp=0", bus_we, bus_be, bus_addr, bus_wdata); end
    n_cmp++; if ({wb_valid, wb_data, wb_rd, misalign, bus_err} !== '0) begin n_bad++; $display("FAIL rst_wb got=%b %h %h %b %b exp=0", wb_valid, wb_data, wb_rd, misalign, bus_err); end
    RST = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    step();
  endtask

  task automatic test_sw();
    issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0, 5'd0);
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL sw_req got=%b exp=1", bus_req); end
    n_cmp++; if (bus_we !== 1'b1) begin n_bad++; $display("FAIL sw_we got=%b exp=1", bus_we); end
    n_cmp++; if (bus_addr !== 32'h1000_0004) begin n_bad++; $display("FAIL sw_addr got=%h exp=10000004", bus_addr); end
    n_cmp++; if (bus_be !== 4'b1111) begin n_bad++; $display("FAIL sw_be got=%b exp=1111", bus_be); end
    n_cmp++; if (bus_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", bus_wdata); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL sw_busy got=%b exp=0", req_ready); end
    step();
    n_cmp++; if ({bus_req, bus_be, bus_wdata} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL sw_hold got=%b %b %h exp=1 1111 deadbeef", bus_req, bus_be, bus_wdata); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL sw_req_drop got=%b exp=0", bus_req); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL sw_no_wb got=%b exp=0", wb_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sw_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_byte();
    issue(1'b1, 32'h0000_0013, 32'h0000_00A5, 2'b00, 1'b0, 5'd0);
    n_cmp++; if (bus_be !== 4'b1000) begin n_bad++; $display("FAIL sb_be got=%b exp=1000", bus_be); end
    n_cmp++; if (bus_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus_wdata); end
    n_cmp++; if (bus_addr !== 32'h0000_0010) begin n_bad++; $display("FAIL sb_addr got=%h exp=00000010", bus_addr); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL sb_no_wb got=%b exp=0", wb_valid); end

    issue(1'b0, 32'h0000_0013, 32'h0, 2'b00, 1'b0, 5'd7);
    n_cmp++; if ({bus_we, bus_be} !== {1'b0, 4'hF}) begin n_bad++; $display("FAIL lb_bus got=%b %b exp=0 1111", bus_we, bus_be); end
    bus_ack = 1'b1; bus_rdata = 32'h80FF_00AA;
    step();
    bus_ack = 1'b0;
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL lb_valid got=%b exp=1", wb_valid); end
    n_cmp++; if (wb_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got=%h exp=ffffff80", wb_data); end
    n_cmp++; if (wb_rd !== 5'd7) begin n_bad++; $display("FAIL lb_rd got=%0d exp=7", wb_rd); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL lb_ready got=%b exp=1", req_ready); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL lb_pulse got=%b exp=0", wb_valid); end
    n_cmp++; if (wb_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_hold got=%h exp=ffffff80", wb_data); end

    issue(1'b0, 32'h0000_0013, 32'h0, 2'b00, 1'b1, 5'd7);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_0080}) begin n_bad++; $display("FAIL lbu_data got=%b %h exp=1 00000080", wb_valid, wb_data); end
  endtask

  task automatic test_half_word();
    issue(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b0, 5'd9);
    bus_ack = 1'b1; bus_rdata = 32'h8001_1234;
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'hFFFF_8001, 5'd9}) begin n_bad++; $display("FAIL lh_data got=%b %h %0d exp=1 ffff8001 9", wb_valid, wb_data, wb_rd); end
    issue(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b1, 5'd10);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_8001}) begin n_bad++; $display("FAIL lhu_data got=%b %h exp=1 00008001", wb_valid, wb_data); end
    issue(1'b0, 32'h0000_2000, 32'h0, 2'b01, 1'b0, 5'd11);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_cmp++; if (wb_data !== 32'h0000_1234) begin n_bad++; $display("FAIL lh_lo got=%h exp=00001234", wb_data); end
    issue(1'b1, 32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b0, 5'd0);
    n_cmp++; if ({bus_be, bus_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin n_bad++; $display("FAIL sh_fmt got=%b %h exp=1100 beefbeef", bus_be, bus_wdata); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    issue(1'b0, 32'h0000_2008, 32'h0, 2'b10, 1'b0, 5'd12);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h1234_5678, 5'd12}) begin n_bad++; $display("FAIL lw_data got=%b %h %0d exp=1 12345678 12", wb_valid, wb_data, wb_rd); end
  endtask

  task automatic test_misalign();
    int pulses = 0;
    int reqs = 0;
    mem_we = 1'b0; ALU_RESULT = 32'h0000_3006; size = 2'b10;
    req_valid = 1'b1;
    step();
    pulses += misalign; reqs += bus_req;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mis_ready got=%b exp=1", req_ready); end
    mem_we = 1'b1; ALU_RESULT = 32'h0000_3001; size = 2'b01;
    step();
    pulses += misalign; reqs += bus_req;
    mem_we = 1'b0; ALU_RESULT = 32'h0000_3000; size = 2'b11;
    step();
    pulses += misalign; reqs += bus_req;
    req_valid = 1'b0;
    step();
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_end got=%b exp=0", misalign); end
    reqs += bus_req;
    n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL mis_pulses got=%0d exp=3", pulses); end
    n_cmp++; if (reqs != 0) begin n_bad++; $display("FAIL mis_bus_req got=%0d exp=0", reqs); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, bus_err} !== 2'b00) begin n_bad++; $display("FAIL idle_ack got=%b%b exp=00", wb_valid, bus_err); end
  endtask

  task automatic test_timeout();
    int high = 0;
    issue(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      high += bus_req;
      n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL to_early_err cyc=%0d got=%b exp=0", i + 1, bus_err); end
      step();
    end
    n_cmp++; if (high != 4) begin n_bad++; $display("FAIL to_req_cycles got=%0d exp=4", high); end
    n_cmp++; if ({bus_req, bus_err, wb_valid} !== 3'b010) begin n_bad++; $display("FAIL to_err got=%b%b%b exp=010", bus_req, bus_err, wb_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready got=%b exp=1", req_ready); end
    step();
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse got=%b exp=0", bus_err); end

    issue(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0, 5'd4);
    step(); step(); step();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, bus_err} !== 2'b10) begin n_bad++; $display("FAIL ack4_flags got=%b%b exp=10", wb_valid, bus_err); end
    n_cmp++; if (wb_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ack4_data got=%h exp=cafef00d", wb_data); end
    step();
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL ack4_no_err got=%b exp=0", bus_err); end
  endtask

  task automatic test_back_to_back();
    mem_we = 1'b0; ALU_RESULT = 32'h0000_0100; size = 2'b10;
    rd_in = 5'd1; req_valid = 1'b1;
    step();
    ALU_RESULT = 32'h0000_0104; rd_in = 5'd2;
    bus_ack = 1'b1; bus_rdata = 32'h0000_0111;
    n_cmp++; if (bus_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL b2b_addr1 got=%h exp=00000100", bus_addr); end
    step();
    n_cmp++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h0000_0111, 5'd1}) begin n_bad++; $display("FAIL b2b_wb1 got=%b %h %0d exp=1 00000111 1", wb_valid, wb_data, wb_rd); end
    n_cmp++; if ({req_ready, bus_req} !== 2'b10) begin n_bad++; $display("FAIL b2b_ready got=%b%b exp=10", req_ready, bus_req); end
    bus_rdata = 32'h0000_0222;
    step();
    req_valid = 1'b0;
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0104}) begin n_bad++; $display("FAIL b2b_addr2 got=%b %h exp=1 00000104", bus_req, bus_addr); end
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h0000_0222, 5'd2}) begin n_bad++; $display("FAIL b2b_wb2 got=%b %h %0d exp=1 00000222 2", wb_valid, wb_data, wb_rd); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h0000_0080, 32'h0, 2'b10, 1'b0, 5'd5);
    step();
    RST = 1'b1;
    step();
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rm_req got=%b exp=0", bus_req); end
    n_cmp++; if ({bus_we, bus_be, bus_addr, wb_valid, wb_data, wb_rd, misalign, bus_err} !== '0) begin n_bad++; $display("FAIL rm_outs got=%b %b %h %b %h %h %b %b exp=0", bus_we, bus_be, bus_addr, wb_valid, wb_data, wb_rd, misalign, bus_err); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready_rst got=%b exp=0", req_ready); end
    RST = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got=%b exp=1", req_ready); end
    step();
    bus_ack = 1'b0;
    n_cmp++; if ({wb_valid, bus_err, bus_req} !== 3'b000) begin n_bad++; $display("FAIL rm_late_ack got=%b%b%b exp=000", wb_valid, bus_err, bus_req); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_byte();
    test_half_word();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
